cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/fastica_pkg.sv | 25 ++
 rtl/cordic_arbiter_rr_select.sv | 25 ++
 rtl/cordic_arbiter.sv | 159 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fastica_pkg.sv
// Shared FastICA definitions: CORDIC widths, arbiter FSM encoding and
// sizing helpers used by the CORDIC arbiter and its round-robin selector.
package fastica_pkg;

  localparam int CORDIC_DW     = 16;
  localparam int CORDIC_AW     = 16;
  localparam int CORDIC_STAGES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_FLUSH
  } arb_state_t;

  // Must hold 0..stages+1 outstanding operations.
  function automatic int cnt_width(input int stages);
    return $clog2(stages + 2);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_select.sv
// Round-robin one-hot selector: search starts one past ptr and wraps,
// so the requester at ptr itself has the lowest priority.
module rr_select
  import fastica_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int PW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);

  // Walk farthest-to-nearest so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[PW'((int'(ptr) + k) % N_REQ)]) begin
        grant = '0;
        grant[PW'((int'(ptr) + k) % N_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC between N_REQ requesters; a session is held until the
// owner drops req and every issued operation has returned its strobe.
module cordic_arbiter
  import fastica_pkg::*;
#(
  parameter int DATA_WIDTH    = CORDIC_DW,
  parameter int ANGLE_WIDTH   = CORDIC_AW,
  parameter int CORDIC_STAGES = fastica_pkg::CORDIC_STAGES,
  parameter int N_REQ         = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ-1:0]             req,
  output logic [N_REQ-1:0]             gnt,
  input  logic [N_REQ-1:0]             req_vec_en,
  input  logic [N_REQ-1:0]             req_rot_en,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_vec_xin,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_vec_yin,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_rot_xin,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_rot_yin,
  input  logic [N_REQ*2-1:0]           req_rot_quad_in,
  input  logic [N_REQ*ANGLE_WIDTH-1:0] req_rot_angle_in,
  input  logic [N_REQ-1:0]             req_rot_microRot_n,
  output logic                         cordic_vec_en,
  output logic                         cordic_rot_en,
  output logic [DATA_WIDTH-1:0]        cordic_vec_xin,
  output logic [DATA_WIDTH-1:0]        cordic_vec_yin,
  output logic [DATA_WIDTH-1:0]        cordic_rot_xin,
  output logic [DATA_WIDTH-1:0]        cordic_rot_yin,
  output logic [1:0]                   cordic_rot_quad_in,
  output logic [ANGLE_WIDTH-1:0]       cordic_rot_angle_in,
  output logic                         cordic_rot_angle_microRot_n,
  output logic                         cordic_nrst,
  input  logic                         cordic_vec_opvld,
  input  logic                         cordic_rot_opvld,
  output logic [N_REQ-1:0]             gnt_vec_opvld,
  output logic [N_REQ-1:0]             gnt_rot_opvld,
  output logic                         busy
);

  localparam int CW = cnt_width(CORDIC_STAGES);
  localparam int PW = idx_width(N_REQ);
  localparam logic [CW-1:0] CNT_MAX = CW'(CORDIC_STAGES + 1);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    rr_idx;
  logic [N_REQ-1:0] rr_gnt;
  logic [CW-1:0]    vec_cnt;
  logic [CW-1:0]    rot_cnt;
  logic [CW-1:0]    vec_cnt_nxt;
  logic [CW-1:0]    rot_cnt_nxt;
  logic             granted;
  logic             routing;
  logic             vec_pass;
  logic             rot_pass;

  rr_select #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req  (req),
    .ptr  (ptr),
    .grant(rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_gnt[i]) rr_idx = PW'(i);
    end
  end

  assign granted  = (state == ST_GRANT);
  assign routing  = granted || (state == ST_DRAIN);
  assign vec_pass = granted && |(req_vec_en & gnt);
  assign rot_pass = granted && |(req_rot_en & gnt);

  function automatic logic [CW-1:0] step(
    input logic [CW-1:0] c,
    input logic          inc,
    input logic          dec
  );
    case ({inc, dec})
      2'b10:   return (c == CNT_MAX) ? c : c + CW'(1);
      2'b01:   return (c == '0) ? c : c - CW'(1);
      default: return c;
    endcase
  endfunction

  assign vec_cnt_nxt = step(vec_cnt, vec_pass, cordic_vec_opvld);
  assign rot_cnt_nxt = step(rot_cnt, rot_pass, cordic_rot_opvld);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      ptr     <= PW'(N_REQ - 1);
      vec_cnt <= '0;
      rot_cnt <= '0;
    end else begin
      vec_cnt <= vec_cnt_nxt;
      rot_cnt <= rot_cnt_nxt;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= rr_gnt;
            ptr   <= rr_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (~|(req & gnt)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (vec_cnt_nxt == '0 && rot_cnt_nxt == '0) begin
            gnt   <= '0;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Only the owner reaches the CORDIC, and only while in GRANT.
  always_comb begin
    cordic_vec_en               = 1'b0;
    cordic_rot_en               = 1'b0;
    cordic_vec_xin              = '0;
    cordic_vec_yin              = '0;
    cordic_rot_xin              = '0;
    cordic_rot_yin              = '0;
    cordic_rot_quad_in          = '0;
    cordic_rot_angle_in         = '0;
    cordic_rot_angle_microRot_n = 1'b0;
    if (granted) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          cordic_vec_en       = req_vec_en[i];
          cordic_rot_en       = req_rot_en[i];
          cordic_vec_xin      = req_vec_xin[i*DATA_WIDTH +: DATA_WIDTH];
          cordic_vec_yin      = req_vec_yin[i*DATA_WIDTH +: DATA_WIDTH];
          cordic_rot_xin      = req_rot_xin[i*DATA_WIDTH +: DATA_WIDTH];
          cordic_rot_yin      = req_rot_yin[i*DATA_WIDTH +: DATA_WIDTH];
          cordic_rot_quad_in  = req_rot_quad_in[i*2 +: 2];
          cordic_rot_angle_in = req_rot_angle_in[i*ANGLE_WIDTH +: ANGLE_WIDTH];
          cordic_rot_angle_microRot_n = req_rot_microRot_n[i];
        end
      end
    end
  end

  assign cordic_nrst   = routing;
  assign busy          = (state != ST_IDLE);
  assign gnt_vec_opvld = routing ? (gnt & {N_REQ{cordic_vec_opvld}}) : '0;
  assign gnt_rot_opvld = routing ? (gnt & {N_REQ{cordic_rot_opvld}}) : '0;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized sessions against a session-level model of the arbiter:
// round-robin order, outstanding-op bookkeeping and drain/flush timing.
module tb_cordic_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int ST  = 16;
  localparam int N   = 3;
  localparam int SAT = ST + 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N-1:0]    req_vec_en;
  logic [N-1:0]    req_rot_en;
  logic [N*DW-1:0] req_vec_xin;
  logic [N*DW-1:0] req_vec_yin;
  logic [N*DW-1:0] req_rot_xin;
  logic [N*DW-1:0] req_rot_yin;
  logic [N*2-1:0]  req_rot_quad_in;
  logic [N*AW-1:0] req_rot_angle_in;
  logic [N-1:0]    req_rot_microRot_n;
  logic            cordic_vec_en;
  logic            cordic_rot_en;
  logic [DW-1:0]   cordic_vec_xin;
  logic [DW-1:0]   cordic_vec_yin;
  logic [DW-1:0]   cordic_rot_xin;
  logic [DW-1:0]   cordic_rot_yin;
  logic [1:0]      cordic_rot_quad_in;
  logic [AW-1:0]   cordic_rot_angle_in;
  logic            cordic_rot_angle_microRot_n;
  logic            cordic_nrst;
  logic            cordic_vec_opvld;
  logic            cordic_rot_opvld;
  logic [N-1:0]    gnt_vec_opvld;
  logic [N-1:0]    gnt_rot_opvld;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last   = N - 1;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .DATA_WIDTH   (DW),
    .ANGLE_WIDTH  (AW),
    .CORDIC_STAGES(ST),
    .N_REQ        (N)
  ) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .req                        (req),
    .gnt                        (gnt),
    .req_vec_en                 (req_vec_en),
    .req_rot_en                 (req_rot_en),
    .req_vec_xin                (req_vec_xin),
    .req_vec_yin                (req_vec_yin),
    .req_rot_xin                (req_rot_xin),
    .req_rot_yin                (req_rot_yin),
    .req_rot_quad_in            (req_rot_quad_in),
    .req_rot_angle_in           (req_rot_angle_in),
    .req_rot_microRot_n         (req_rot_microRot_n),
    .cordic_vec_en              (cordic_vec_en),
    .cordic_rot_en              (cordic_rot_en),
    .cordic_vec_xin             (cordic_vec_xin),
    .cordic_vec_yin             (cordic_vec_yin),
    .cordic_rot_xin             (cordic_rot_xin),
    .cordic_rot_yin             (cordic_rot_yin),
    .cordic_rot_quad_in         (cordic_rot_quad_in),
    .cordic_rot_angle_in        (cordic_rot_angle_in),
    .cordic_rot_angle_microRot_n(cordic_rot_angle_microRot_n),
    .cordic_nrst                (cordic_nrst),
    .cordic_vec_opvld           (cordic_vec_opvld),
    .cordic_rot_opvld           (cordic_rot_opvld),
    .gnt_vec_opvld              (gnt_vec_opvld),
    .gnt_rot_opvld              (gnt_rot_opvld),
    .busy                       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    req              = '0;
    req_vec_en       = '0;
    req_rot_en       = '0;
    cordic_vec_opvld = 1'b0;
    cordic_rot_opvld = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_vec_xin[i*DW +: DW]      = DW'($urandom);
      req_vec_yin[i*DW +: DW]      = DW'($urandom);
      req_rot_xin[i*DW +: DW]      = DW'($urandom);
      req_rot_yin[i*DW +: DW]      = DW'($urandom);
      req_rot_angle_in[i*AW +: AW] = AW'($urandom);
      req_rot_quad_in[i*2 +: 2]    = 2'($urandom);
    end
    req_rot_microRot_n = N'($urandom);
  endtask

  task automatic do_reset();
    quiet();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    last = N - 1;
  endtask

  // Next owner: first requester after the previous owner, wrapping.
  function automatic int rr_next(input int from, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // One full session from an IDLE cycle through FLUSH back to IDLE.
  task automatic session(input logic [N-1:0] mask, input int nv,
                         input int nr, input int lat_lo,
                         input int lat_hi, input int hold);
    int g, phase, vi, ri, hv, vout, rout, vlast, rlast;
    int vq[$];
    int rq[$];
    logic ve, re, rg, vo, ro;
    logic [N-1:0] eg;
    bit done;
    rand_data();
    req_vec_en       = N'($urandom);
    req_rot_en       = N'($urandom);
    req              = mask;
    cordic_vec_opvld = 1'($urandom);
    cordic_rot_opvld = 1'($urandom);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_nrst", cordic_nrst, 0);
    chk("idle_ven", cordic_vec_en, 0);
    chk("idle_vopv", gnt_vec_opvld, 0);
    chk("idle_ropv", gnt_rot_opvld, 0);
    g = rr_next(last, mask);
    last = g;
    tick();
    phase = 0; vi = 0; ri = 0; hv = 0;
    vout = 0; rout = 0; vlast = 0; rlast = 0;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      rand_data();
      if (g != 2) req_vec_xin[2*DW +: DW] = 16'h1234;
      ve = (phase == 0) && (vi < nv);
      re = (phase == 0) && (ri < nr);
      rg = (phase == 0) && (vi < nv || ri < nr || hv < hold);
      req_vec_en    = N'($urandom);
      req_rot_en    = N'($urandom);
      req_vec_en[g] = ve;
      req_rot_en[g] = re;
      req           = N'($urandom);
      req[g]        = rg;
      vo = (vq.size() > 0) && (vq[0] == cyc);
      ro = (rq.size() > 0) && (rq[0] == cyc);
      cordic_vec_opvld = vo;
      cordic_rot_opvld = ro;
      #1;
      eg = '0;
      if (phase < 2) eg[g] = 1'b1;
      chk("gnt", gnt, eg);
      chk("busy", busy, 1);
      chk("nrst", cordic_nrst, phase < 2);
      chk("vec_en", cordic_vec_en, ve);
      chk("rot_en", cordic_rot_en, re);
      chk("vec_xin", cordic_vec_xin,
          (phase == 0) ? req_vec_xin[g*DW +: DW] : 0);
      chk("vec_yin", cordic_vec_yin,
          (phase == 0) ? req_vec_yin[g*DW +: DW] : 0);
      chk("rot_xin", cordic_rot_xin,
          (phase == 0) ? req_rot_xin[g*DW +: DW] : 0);
      chk("rot_yin", cordic_rot_yin,
          (phase == 0) ? req_rot_yin[g*DW +: DW] : 0);
      chk("rot_ang", cordic_rot_angle_in,
          (phase == 0) ? req_rot_angle_in[g*AW +: AW] : 0);
      chk("rot_quad", cordic_rot_quad_in,
          (phase == 0) ? req_rot_quad_in[g*2 +: 2] : 0);
      chk("rot_mrot", cordic_rot_angle_microRot_n,
          (phase == 0) ? req_rot_microRot_n[g] : 0);
      chk("vec_opv", gnt_vec_opvld, vo ? eg : 0);
      chk("rot_opv", gnt_rot_opvld, ro ? eg : 0);
      if (vo) void'(vq.pop_front());
      if (ro) void'(rq.pop_front());
      if (ve) begin
        vlast = cyc + $urandom_range(lat_hi, lat_lo);
        if (vq.size() > 0 && vlast <= vq[$]) vlast = vq[$] + 1;
        vq.push_back(vlast);
        vi++;
      end
      if (re) begin
        rlast = cyc + $urandom_range(lat_hi, lat_lo);
        if (rq.size() > 0 && rlast <= rq[$]) rlast = rq[$] + 1;
        rq.push_back(rlast);
        ri++;
      end
      if (ve && !vo) vout = (vout < SAT) ? vout + 1 : vout;
      else if (vo && !ve) vout = (vout > 0) ? vout - 1 : 0;
      if (re && !ro) rout = (rout < SAT) ? rout + 1 : rout;
      else if (ro && !re) rout = (rout > 0) ? rout - 1 : 0;
      if (rg && !ve && !re) hv++;
      if (phase == 2) done = 1;
      else if (phase == 1 && vout == 0 && rout == 0) phase = 2;
      else if (phase == 0 && !rg) phase = 1;
      tick();
    end
    if (!done) chk("session_timeout", 0, 1);
    quiet();
  endtask

  initial begin
    rand_data();
    quiet();
    rstn             = 1'b0;
    req              = '1;
    req_vec_en       = '1;
    req_rot_en       = '1;
    cordic_vec_opvld = 1'b1;
    cordic_rot_opvld = 1'b1;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nrst", cordic_nrst, 0);
    chk("rst_ven", cordic_vec_en, 0);
    chk("rst_ren", cordic_rot_en, 0);
    chk("rst_vxin", cordic_vec_xin, 0);
    chk("rst_vopv", gnt_vec_opvld, 0);
    chk("rst_ropv", gnt_rot_opvld, 0);
    tick();
    chk("rst_gnt_held", gnt, 0);
    do_reset();

    // Requester 1 alone, three vector ops back after 16 cycles.
    session(3'b010, 3, 0, 16, 16, 0);

    // All requesting from reset: rotation order over four sessions.
    do_reset();
    for (int s = 0; s < 4; s++) session(3'b111, 0, 0, 1, 1, 4);

    // Two rotations outstanding when requester 0 lets go.
    session(3'b001, 0, 2, 3, 8, 0);

    // One-cycle latency: enable and strobe coincide.
    session(3'b010, 3, 0, 1, 1, 0);

    // More ops than the counter can hold.
    session(3'b100, 20, 0, 30, 30, 0);

    for (int s = 0; s < 8; s++) begin
      session(N'($urandom_range(7, 1)), $urandom_range(4, 0),
              $urandom_range(4, 0), 1, 12, $urandom_range(3, 0));
    end

    // Reset in the middle of a drain with three ops in flight.
    do_reset();
    rand_data();
    req = 3'b001;
    tick();
    chk("r38_gnt", gnt, 3'b001);
    for (int i = 0; i < 3; i++) begin
      req_vec_en = 3'b001;
      tick();
    end
    req_vec_en = '0;
    req        = '0;
    tick();
    chk("r38_drain_gnt", gnt, 3'b001);
    chk("r38_drain_busy", busy, 1);
    rstn             = 1'b0;
    cordic_vec_opvld = 1'b1;
    #1;
    chk("r38_gnt0", gnt, 0);
    chk("r38_busy0", busy, 0);
    chk("r38_nrst0", cordic_nrst, 0);
    chk("r38_vopv0", gnt_vec_opvld, 0);
    tick();
    rstn = 1'b1;
    last = N - 1;
    for (int i = 0; i < 3; i++) begin
      cordic_vec_opvld = 1'b1;
      #1;
      chk("r38_late_vopv", gnt_vec_opvld, 0);
      chk("r38_late_busy", busy, 0);
      tick();
    end
    cordic_vec_opvld = 1'b0;
    session(3'b001, 0, 0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
